// File: rtl/sys_run_ctrl_pkg.sv
// Shared encodings for the debug run-control sequencer: command ops,
// sequencer states and halt causes as seen on the debug front-end.
package sys_run_ctrl_pkg;

    localparam logic [1:0] OP_HALT = 2'd0;
    localparam logic [1:0] OP_STEP = 2'd1;
    localparam logic [1:0] OP_RUN  = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_STEP = 2'd1;
    localparam logic [1:0] CAUSE_BP   = 2'd2;
    localparam logic [1:0] CAUSE_EXC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2,
        ST_LOAD = 2'd3
    } state_t;

    function automatic logic is_issuing(state_t s);
        return (s == ST_STEP) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/sys_run_ctrl_if.sv
// Debug command channel plus core-facing run-control signals.
// master = debug front-end / core side, slave = sys_run_ctrl.
interface sys_run_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int ARG_W  = 8,
    parameter int CNT_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ARG_W-1:0]  cmd_arg;
    logic              bp_en;
    logic [ADDR_W-1:0] bp_addr;
    logic [ADDR_W-1:0] pc_addr;
    logic              exc_in;
    logic              cpu_en;
    logic              pc_load_en;
    logic [ARG_W-1:0]  pc_load_val;
    logic [1:0]        run_state;
    logic [1:0]        halt_cause;
    logic [CNT_W-1:0]  retired_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, bp_en, bp_addr, pc_addr, exc_in,
        input  cmd_ready, cpu_en, pc_load_en, pc_load_val, run_state, halt_cause, retired_cnt
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, bp_en, bp_addr, pc_addr, exc_in,
        output cmd_ready, cpu_en, pc_load_en, pc_load_val, run_state, halt_cause, retired_cnt
    );
endinterface

// File: rtl/sys_run_ctrl_sat.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/sys_run_ctrl.sv
// Debug run-control sequencer: gates the core with cpu_en, handles
// HALT/STEP/RUN/LOAD, and stops on breakpoint, exception or step exhaustion.
module sys_run_ctrl
    import sys_run_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int ARG_W    = 8,
    parameter int CNT_W    = 16,
    parameter int LOAD_CYC = 2
) (
    input  logic          SYS_clk,
    input  logic          SYS_reset,
    sys_run_ctrl_if.slave bus
);
    localparam int LC_W = $clog2(LOAD_CYC + 1);

    state_t            state;
    logic [ARG_W-1:0]  remain;
    logic [LC_W-1:0]   load_cnt;
    logic              resume;
    logic              load_en_q;
    logic [ARG_W-1:0]  load_val_q;
    logic [1:0]        cause_q;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] bp;
    logic              issuing;
    logic              cmd_ready;
    logic              cmd_acc;
    logic              halt_acc;
    logic              bp_hit;
    logic              cpu_en;
    logic              step_last;
    logic              load_acc;

    assign pc        = bus.pc_addr;
    assign bp        = bus.bp_addr;
    assign issuing   = is_issuing(state);
    assign cmd_ready = (state == ST_IDLE) | ((state != ST_LOAD) & (bus.cmd_op == OP_HALT));
    assign cmd_acc   = bus.cmd_valid & cmd_ready;
    assign halt_acc  = issuing & cmd_acc & (bus.cmd_op == OP_HALT);
    // resume masks the breakpoint until the first instruction issues,
    // so a run can restart from the PC it stopped on.
    assign bp_hit    = bus.bp_en & ~resume & (pc == bp);
    assign cpu_en    = issuing & ~halt_acc & ~bp_hit;
    assign step_last = (state == ST_STEP) & (remain == ARG_W'(1));
    assign load_acc  = cmd_acc & (state == ST_IDLE) & (bus.cmd_op == OP_LOAD);

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state      <= ST_IDLE;
            remain     <= '0;
            load_cnt   <= '0;
            resume     <= 1'b0;
            load_en_q  <= 1'b0;
            load_val_q <= '0;
            cause_q    <= CAUSE_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_acc) begin
                        cause_q <= CAUSE_NONE;
                        case (bus.cmd_op)
                            OP_STEP: begin
                                state  <= ST_STEP;
                                remain <= (bus.cmd_arg == '0) ? ARG_W'(1) : bus.cmd_arg;
                                resume <= 1'b1;
                            end
                            OP_RUN: begin
                                state  <= ST_RUN;
                                resume <= 1'b1;
                            end
                            OP_LOAD: begin
                                state      <= ST_LOAD;
                                load_en_q  <= 1'b1;
                                load_val_q <= bus.cmd_arg;
                                load_cnt   <= LC_W'(LOAD_CYC);
                            end
                            default: ;
                        endcase
                    end
                end
                ST_STEP, ST_RUN: begin
                    if (cpu_en) begin
                        resume <= 1'b0;
                        if (state == ST_STEP) remain <= remain - ARG_W'(1);
                    end
                    // An exception only wins if the instruction actually issued.
                    if (cpu_en && bus.exc_in) begin
                        state   <= ST_IDLE;
                        cause_q <= CAUSE_EXC;
                    end else if (halt_acc) begin
                        state   <= ST_IDLE;
                        cause_q <= CAUSE_NONE;
                    end else if (bp_hit) begin
                        state   <= ST_IDLE;
                        cause_q <= CAUSE_BP;
                    end else if (cpu_en && step_last) begin
                        state   <= ST_IDLE;
                        cause_q <= CAUSE_STEP;
                    end
                end
                ST_LOAD: begin
                    if (load_cnt == LC_W'(1)) begin
                        state     <= ST_IDLE;
                        load_en_q <= 1'b0;
                        cause_q   <= CAUSE_NONE;
                    end else begin
                        load_cnt <= load_cnt - LC_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_retired (
        .clk   (SYS_clk),
        .rst_n (SYS_reset),
        .inc   (cpu_en),
        .clr   (load_acc),
        .cnt   (bus.retired_cnt)
    );

    assign bus.cmd_ready   = cmd_ready;
    assign bus.cpu_en      = cpu_en;
    assign bus.pc_load_en  = load_en_q;
    assign bus.pc_load_val = load_val_q;
    assign bus.run_state   = state;
    assign bus.halt_cause  = cause_q;

endmodule

// File: tb/tb_sys_run_ctrl.sv
// Bench for sys_run_ctrl: command table, directed corner sequences and a
// random phase, all checked every cycle against a behavioural model.
module tb_sys_run_ctrl;
    localparam int LOAD_CYC = 2;

    logic SYS_clk;
    logic SYS_reset;

    sys_run_ctrl_if #(.ADDR_W(32), .ARG_W(8), .CNT_W(16)) bus ();

    sys_run_ctrl #(.ADDR_W(32), .ARG_W(8), .CNT_W(16), .LOAD_CYC(LOAD_CYC)) dut (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .bus       (bus)
    );

    initial SYS_clk = 1'b0;
    always #5 SYS_clk = ~SYS_clk;

    int n_chk;
    int n_err;

    // model: mode 0 idle, 1 stepping, 2 running, 3 loading
    int m_mode, m_left, m_load_left, m_cause, m_cnt, m_lval;
    bit m_fresh;
    int pc;
    bit last_en, last_ld;

    typedef struct {
        int op; int arg; int bp_en; int bp_addr;
        int exp_en; int exp_ld; int exp_cause; int exp_cnt;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        SYS_reset     = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_arg   = 8'd0;
        bus.bp_en     = 1'b0;
        bus.bp_addr   = 32'd0;
        bus.exc_in    = 1'b0;
        m_mode = 0; m_left = 0; m_load_left = 0; m_cause = 0; m_cnt = 0; m_lval = 0;
        m_fresh = 1'b0;
        pc = 0;
        bus.pc_addr = 32'd0;
        #2;
        SYS_reset = 1'b1;
        @(posedge SYS_clk);
        #1;
    endtask

    // One clock: compare against the model just before the edge, then advance it.
    task automatic tick(input bit do_chk);
        bit busy, rdy, acc, halt, bp, ecpu;
        int op, arg;
        #1;
        op   = int'(bus.cmd_op);
        arg  = int'(bus.cmd_arg);
        busy = (m_mode == 1) || (m_mode == 2);
        rdy  = (m_mode == 0) || (m_mode != 3 && op == 0);
        acc  = bus.cmd_valid && rdy;
        halt = busy && acc && op == 0;
        bp   = bus.bp_en && !m_fresh && (bus.pc_addr == bus.bp_addr);
        ecpu = busy && !halt && !bp;
        last_en = bus.cpu_en;
        last_ld = bus.pc_load_en;
        if (do_chk) begin
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(rdy));
            chk("cpu_en", 32'(bus.cpu_en), 32'(ecpu));
            chk("pc_load_en", 32'(bus.pc_load_en), 32'(m_mode == 3));
            chk("pc_load_val", 32'(bus.pc_load_val), m_lval);
            chk("run_state", 32'(bus.run_state), m_mode);
            chk("halt_cause", 32'(bus.halt_cause), m_cause);
            chk("retired_cnt", 32'(bus.retired_cnt), m_cnt);
        end
        @(posedge SYS_clk);
        if (ecpu) pc += 4;
        if (m_mode == 3) pc = m_lval;
        case (m_mode)
            0: if (acc) begin
                m_cause = 0;
                if (op == 1) begin m_mode = 1; m_left = (arg == 0) ? 1 : arg; m_fresh = 1'b1; end
                else if (op == 2) begin m_mode = 2; m_fresh = 1'b1; end
                else if (op == 3) begin m_mode = 3; m_load_left = LOAD_CYC; m_lval = arg; m_cnt = 0; end
            end
            1, 2: begin
                if (ecpu) begin
                    m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    m_fresh = 1'b0;
                    m_left--;
                end
                if (ecpu && bus.exc_in) begin m_mode = 0; m_cause = 3; end
                else if (halt) begin m_mode = 0; m_cause = 0; end
                else if (bp) begin m_mode = 0; m_cause = 2; end
                else if (m_mode == 1 && ecpu && m_left == 0) begin m_mode = 0; m_cause = 1; end
            end
            default: begin
                m_load_left--;
                if (m_load_left == 0) begin m_mode = 0; m_cause = 0; end
            end
        endcase
        #1;
        bus.pc_addr = 32'(pc);
    endtask

    task automatic issue(input int op, input int arg);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'(op);
        bus.cmd_arg   = 8'(arg);
        tick(1'b1);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        // op, arg, bp_en, bp_addr, cpu_en cycles, load cycles, cause, retired
        vt[0] = '{1, 3,    0, 0,     3,   0, 1, 3};
        vt[1] = '{1, 0,    0, 0,     1,   0, 1, 1};
        vt[2] = '{1, 1,    0, 0,     1,   0, 1, 1};
        vt[3] = '{1, 200,  0, 0,     200, 0, 1, 200};
        vt[4] = '{2, 0,    1, 'h10,  4,   0, 2, 4};
        vt[5] = '{1, 5,    1, 'h8,   2,   0, 2, 2};
        vt[6] = '{1, 2,    1, 'h8,   2,   0, 1, 2};
        vt[7] = '{3, 'h2A, 0, 0,     0,   2, 0, 0};

        do_reset();

        // reset mid-RUN takes effect without waiting for a clock
        issue(2, 0);
        repeat (5) tick(1'b1);
        chk("pre_reset_cnt", 32'(bus.retired_cnt), 5);
        SYS_reset = 1'b0;
        #1;
        chk("rst_cpu_en", 32'(bus.cpu_en), 0);
        chk("rst_load_en", 32'(bus.pc_load_en), 0);
        chk("rst_load_val", 32'(bus.pc_load_val), 0);
        chk("rst_state", 32'(bus.run_state), 0);
        chk("rst_cause", 32'(bus.halt_cause), 0);
        chk("rst_cnt", 32'(bus.retired_cnt), 0);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            int n_en, n_ld, cyc;
            do_reset();
            bus.bp_en   = (vt[i].bp_en != 0);
            bus.bp_addr = 32'(vt[i].bp_addr);
            issue(vt[i].op, vt[i].arg);
            n_en = 0; n_ld = 0; cyc = 0;
            while (bus.run_state != 2'd0 && cyc < 400) begin
                tick(1'b1);
                n_en += int'(last_en);
                n_ld += int'(last_ld);
                cyc++;
            end
            chk($sformatf("v%0d_done", i), 32'(bus.run_state), 0);
            chk($sformatf("v%0d_en_cycles", i), n_en, vt[i].exp_en);
            chk($sformatf("v%0d_ld_cycles", i), n_ld, vt[i].exp_ld);
            chk($sformatf("v%0d_cause", i), 32'(bus.halt_cause), vt[i].exp_cause);
            chk($sformatf("v%0d_cnt", i), 32'(bus.retired_cnt), vt[i].exp_cnt);
        end

        // breakpoint stop, then resume from the breakpoint PC
        do_reset();
        bus.bp_en = 1'b1;
        bus.bp_addr = 32'h10;
        issue(2, 0);
        repeat (5) tick(1'b1);
        chk("bp_cause", 32'(bus.halt_cause), 2);
        chk("bp_pc", 32'(bus.pc_addr), 'h10);
        issue(2, 0);
        #1;
        chk("resume_cpu_en", 32'(bus.cpu_en), 1);
        tick(1'b1);
        issue(0, 0);
        chk("resume_halt_state", 32'(bus.run_state), 0);
        chk("resume_halt_cause", 32'(bus.halt_cause), 0);

        // exception together with HALT: HALT suppresses the issue
        do_reset();
        issue(2, 0);
        repeat (2) tick(1'b1);
        bus.exc_in = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0;
        #1;
        chk("exc_halt_cpu_en", 32'(bus.cpu_en), 0);
        tick(1'b1);
        bus.exc_in = 1'b0; bus.cmd_valid = 1'b0;
        chk("exc_halt_state", 32'(bus.run_state), 0);
        chk("exc_halt_cause", 32'(bus.halt_cause), 0);
        chk("exc_halt_cnt", 32'(bus.retired_cnt), 2);
        do_reset();
        issue(2, 0);
        repeat (2) tick(1'b1);
        bus.exc_in = 1'b1;
        tick(1'b1);
        bus.exc_in = 1'b0;
        chk("exc_state", 32'(bus.run_state), 0);
        chk("exc_cause", 32'(bus.halt_cause), 3);
        chk("exc_cnt", 32'(bus.retired_cnt), 3);

        // LOAD clears the count and refuses commands while loading
        do_reset();
        issue(1, 3);
        repeat (3) tick(1'b1);
        chk("preload_cnt", 32'(bus.retired_cnt), 3);
        issue(3, 'h2A);
        for (int k = 0; k < LOAD_CYC; k++) begin
            bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2;
            #1;
            chk("ld_ready", 32'(bus.cmd_ready), 0);
            chk("ld_en", 32'(bus.pc_load_en), 1);
            chk("ld_val", 32'(bus.pc_load_val), 'h2A);
            chk("ld_cnt", 32'(bus.retired_cnt), 0);
            tick(1'b1);
        end
        bus.cmd_valid = 1'b0;
        #1;
        chk("ld_done_state", 32'(bus.run_state), 0);
        chk("ld_done_en", 32'(bus.pc_load_en), 0);

        // STEP offered during RUN is held off; counter saturates
        do_reset();
        issue(2, 0);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_arg = 8'd4;
        #1;
        chk("run_step_ready", 32'(bus.cmd_ready), 0);
        chk("run_step_cpu_en", 32'(bus.cpu_en), 1);
        tick(1'b1);
        bus.cmd_valid = 1'b0;
        repeat (65540) tick(1'b0);
        chk("sat_cnt", 32'(bus.retired_cnt), 'hFFFF);
        tick(1'b1);
        chk("sat_hold", 32'(bus.retired_cnt), 'hFFFF);
        issue(0, 0);
        chk("sat_halt_state", 32'(bus.run_state), 0);

        // random traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k % 700 == 699) do_reset();
            bus.cmd_valid = ($urandom_range(0, 3) == 0);
            bus.cmd_op    = 2'($urandom_range(0, 3));
            bus.cmd_arg   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            bus.bp_en     = 1'($urandom_range(0, 1));
            bus.bp_addr   = 32'(pc + 4 * int'($urandom_range(0, 6)));
            bus.exc_in    = ($urandom_range(0, 15) == 0);
            tick(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
